// File: rtl/jop_trace_decoder.sv
// Two-stage retirement-trace classifier feeding jop_alarm.
// Flags indirect jumps (JALR, C.JR, C.JALR) and keeps saturating stats.
module jop_trace_decoder #(
  parameter bit          ExcludeReturns = 1'b1,
  parameter bit          CountCalls     = 1'b1,
  parameter int unsigned CntWidth       = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic                flush_i,
  input  logic                clear_i,
  input  logic                instr_valid_i,
  input  logic [31:0]         instr_i,
  output logic                instr_valid_o,
  output logic                is_ind_jump_o,
  output logic [CntWidth-1:0] ind_jump_cnt_o,
  output logic [CntWidth-1:0] instr_cnt_o
);

  localparam logic [CntWidth-1:0] CntMax = '1;
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  logic                s1_valid;
  logic [31:0]         s1_instr;
  logic                s2_valid;
  logic                s2_flag;
  logic [CntWidth-1:0] jump_cnt;
  logic [CntWidth-1:0] instr_cnt;

  logic [4:0] rd;
  logic [4:0] rs1;
  logic       is_jalr;
  logic       is_cjump;
  logic       is_call;
  logic       is_ret;
  logic       flag;
  logic       unused_imm;

  // Immediate field of JALR does not affect classification.
  assign unused_imm = ^s1_instr[31:20];

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  // Decode the S1 word into jump / call / return and the final flag.
  always_comb begin
    rd       = s1_instr[11:7];
    rs1      = s1_instr[19:15];
    is_jalr  = (s1_instr[6:0] == 7'b1100111)
             && (s1_instr[14:12] == 3'b000);
    is_cjump = (s1_instr[1:0] == 2'b10)
             && (s1_instr[15:13] == 3'b100)
             && (s1_instr[6:2] == 5'd0)
             && (rd != 5'd0);
    is_call  = (is_jalr && is_link(rd))
             || (is_cjump && s1_instr[12]);
    is_ret   = !is_call
             && ((is_jalr && rd == 5'd0 && is_link(rs1))
             || (is_cjump && !s1_instr[12] && is_link(rd)));
    flag     = (is_jalr || is_cjump)
             && !(ExcludeReturns && is_ret)
             && !(!CountCalls && is_call);
  end

  // Stage 1: capture the gated strobe and the raw word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_instr <= '0;
    end else begin
      s1_valid <= instr_valid_i & enable_i & ~flush_i;
      s1_instr <= instr_i;
    end
  end

  // Stage 2: register the classification; flush kills the S1 entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid <= 1'b0;
      s2_flag  <= 1'b0;
    end else begin
      s2_valid <= s1_valid & ~flush_i;
      s2_flag  <= s1_valid & ~flush_i & flag;
    end
  end

  // Saturating stats on emitted entries; clear beats increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_cnt <= '0;
      jump_cnt  <= '0;
    end else if (clear_i) begin
      instr_cnt <= '0;
      jump_cnt  <= '0;
    end else begin
      if (s2_valid && instr_cnt != CntMax)
        instr_cnt <= instr_cnt + CntOne;
      if (s2_valid && s2_flag && jump_cnt != CntMax)
        jump_cnt <= jump_cnt + CntOne;
    end
  end

  assign instr_valid_o  = s2_valid;
  assign is_ind_jump_o  = s2_valid & s2_flag;
  assign ind_jump_cnt_o = jump_cnt;
  assign instr_cnt_o    = instr_cnt;

endmodule

// File: tb/tb_jop_trace_decoder.sv
// Scoreboard bench for jop_trace_decoder.
// Four parameterisations share one stimulus stream.
module tb_jop_trace_decoder;

  localparam int N = 4;
  localparam logic [31:0] J = 32'h00050067;

  typedef struct {
    int k;
    bit f;
  } ent_t;

  logic clk;
  logic rst_ni;
  logic enable_i;
  logic flush_i;
  logic clear_i;
  logic instr_valid_i;
  logic [31:0] instr_i;

  logic [N-1:0] vo;
  logic [N-1:0] jo;
  logic [N-1:0][31:0] jc;
  logic [N-1:0][31:0] ic;

  ent_t q[N][$];
  longint eic[N];
  longint ejc[N];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  bit done = 0;

  function automatic bit ex_of(int g);
    return g != 1;
  endfunction

  function automatic bit cc_of(int g);
    return g != 2;
  endfunction

  function automatic int cw_of(int g);
    return (g == 3) ? 4 : 32;
  endfunction

  for (genvar g = 0; g < N; g++) begin : gi
    localparam bit EXG = (g != 1);
    localparam bit CCG = (g != 2);
    localparam int CWG = (g == 3) ? 4 : 32;
    logic [CWG-1:0] jcw;
    logic [CWG-1:0] icw;
    jop_trace_decoder #(
      .ExcludeReturns(EXG),
      .CountCalls(CCG),
      .CntWidth(CWG)
    ) u_dut (
      .clk_i(clk),
      .rst_ni(rst_ni),
      .enable_i(enable_i),
      .flush_i(flush_i),
      .clear_i(clear_i),
      .instr_valid_i(instr_valid_i),
      .instr_i(instr_i),
      .instr_valid_o(vo[g]),
      .is_ind_jump_o(jo[g]),
      .ind_jump_cnt_o(jcw),
      .instr_cnt_o(icw)
    );
    assign jc[g] = 32'(jcw);
    assign ic[g] = 32'(icw);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: decode straight from the ISA rules.
  function automatic bit model_flag(logic [31:0] w, bit ex, bit cc);
    bit jump;
    bit call;
    bit ret;
    logic [4:0] rd;
    logic [4:0] rs;
    jump = 0;
    call = 0;
    ret = 0;
    rd = w[11:7];
    rs = w[19:15];
    if (w[1:0] == 2'b11) begin
      if (w[6:0] == 7'h67 && w[14:12] == 3'd0) begin
        jump = 1;
        call = rd inside {5'd1, 5'd5};
        ret = !call && rd == 5'd0 && (rs inside {5'd1, 5'd5});
      end
    end else if (w[1:0] == 2'b10 && w[15:13] == 3'b100
                 && w[6:2] == 5'd0 && rd != 5'd0) begin
      jump = 1;
      if (w[12]) call = 1;
      else ret = rd inside {5'd1, 5'd5};
    end
    return jump && !(ex && ret) && !(!cc && call);
  endfunction

  function automatic logic [4:0] pick();
    int s;
    s = $urandom_range(0, 3);
    if (s == 0) return 5'd0;
    if (s == 1) return 5'd1;
    if (s == 2) return 5'd5;
    return 5'($urandom);
  endfunction

  function automatic logic [31:0] rnd_word();
    int s;
    logic [4:0] a;
    logic [4:0] b;
    s = $urandom_range(0, 5);
    a = pick();
    b = pick();
    case (s)
      0: return {12'($urandom), a, 3'b000, b, 7'b1100111};
      1: return {12'($urandom), a, 3'($urandom), b, 7'b1100111};
      2: return {16'($urandom), 3'b100, 1'($urandom), a, 5'd0, 2'b10};
      3: return {16'($urandom), 3'($urandom), 1'($urandom), a,
                 5'($urandom), 2'b10};
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(string nm, int g, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d cyc=%0d got=%0h exp=%0h",
               nm, g, cyc, act, exp);
    end
  endtask

  // Issue one cycle of input and record what each instance must emit.
  task automatic drive(logic [31:0] w, bit v, bit en, bit fl, bit cl);
    int k;
    ent_t e;
    @(posedge clk);
    #1;
    instr_i = w;
    instr_valid_i = v;
    enable_i = en;
    flush_i = fl;
    clear_i = cl;
    k = cyc + 1;
    for (int g = 0; g < N; g++) begin
      if (fl && q[g].size() > 0)
        if (q[g][$].k == k - 1) void'(q[g].pop_back());
      if (v && en && !fl) begin
        e.k = k;
        e.f = model_flag(w, ex_of(g), cc_of(g));
        q[g].push_back(e);
      end
    end
  endtask

  task automatic idle(int n);
    repeat (n) drive(32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: compare outputs and counters against the scoreboard.
  always @(negedge clk) begin
    ent_t e;
    longint mx;
    if (done) begin
      for (int g = 0; g < N; g++)
        chk("drain", g, 64'(q[g].size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
    end else if (!rst_ni) begin
      for (int g = 0; g < N; g++) begin
        chk("rst_out", g, {30'd0, vo[g], jo[g], ic[g]}, 64'd0);
        chk("rst_jcnt", g, 64'(jc[g]), 64'd0);
        eic[g] = 0;
        ejc[g] = 0;
      end
    end else begin
      for (int g = 0; g < N; g++) begin
        mx = (64'd1 << cw_of(g)) - 1;
        chk("instr_cnt", g, 64'(ic[g]), 64'(eic[g]));
        chk("jump_cnt", g, 64'(jc[g]), 64'(ejc[g]));
        if (vo[g]) begin
          if (q[g].size() == 0) begin
            chk("unexpected_out", g, 64'd1, 64'd0);
          end else begin
            e = q[g].pop_front();
            chk("latency", g, 64'(cyc), 64'(e.k + 1));
            chk("flag", g, 64'(jo[g]), 64'(e.f));
            if (eic[g] < mx) eic[g]++;
            if (e.f && ejc[g] < mx) ejc[g]++;
          end
        end else begin
          chk("idle_flag", g, 64'(jo[g]), 64'd0);
          if (q[g].size() > 0 && q[g][0].k + 1 <= cyc) begin
            chk("missing_out", g, 64'd0, 64'd1);
            void'(q[g].pop_front());
          end
        end
        if (clear_i) begin
          eic[g] = 0;
          ejc[g] = 0;
        end
      end
    end
  end

  initial begin
    rst_ni = 1'b0;
    enable_i = 1'b1;
    flush_i = 1'b0;
    clear_i = 1'b0;
    instr_valid_i = 1'b0;
    instr_i = '0;
    repeat (3) @(posedge clk);
    #3 rst_ni = 1'b1;

    drive(J, 1, 1, 0, 0);
    idle(3);

    drive(32'h00008067, 1, 1, 0, 0);
    drive(32'h00008082, 1, 1, 0, 0);
    drive(32'h0000006F, 1, 1, 0, 0);
    drive(32'h00008002, 1, 1, 0, 0);
    idle(3);

    drive(32'h00008502, 1, 1, 0, 0);
    drive(32'h00009502, 1, 1, 0, 0);
    drive(32'hFFFF8502, 1, 1, 0, 0);
    drive(32'hFFFF9502, 1, 1, 0, 0);
    drive(32'h000080E7, 1, 1, 0, 0);
    drive(32'h000280E7, 1, 1, 0, 0);
    drive(32'h00009002, 1, 1, 0, 0);
    idle(3);

    for (int i = 0; i < 5; i++) drive(J, 1, 1, i == 2, 0);
    idle(2);
    for (int i = 0; i < 4; i++) drive(J, 1, !(i == 1 || i == 2), 0, 0);
    idle(2);

    repeat (20) drive(J, 1, 1, 0, 0);
    drive(J, 1, 1, 0, 1);
    drive(J, 1, 1, 0, 0);
    idle(3);

    drive(J, 1, 1, 0, 0);
    drive(J, 1, 1, 0, 0);
    @(posedge clk);
    #3;
    instr_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    for (int g = 0; g < N; g++) q[g].delete();
    @(posedge clk);
    #3 rst_ni = 1'b1;
    idle(3);
    drive(J, 1, 1, 0, 0);
    idle(3);

    repeat (2000) begin
      drive(rnd_word(),
            $urandom_range(0, 9) < 8,
            $urandom_range(0, 19) != 0,
            $urandom_range(0, 32) == 0,
            $urandom_range(0, 49) == 0);
    end
    idle(5);
    done = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL timeout monitor did not finish");
    $fatal(1);
  end

endmodule

// File: doc/jop_trace_decoder.md
# jop_trace_decoder

Two-stage pipelined classifier between the core's retirement trace port and `jop_alarm`. Each retired instruction word is decoded to decide whether it is an indirect jump: RV32 JALR, C.JR or C.JALR, with optional exclusion of returns and calls. Outputs are the `instr_valid` / `is_ind_jump` pair consumed by `jop_alarm`, plus saturating statistics counters that firmware reads through a CSR wrapper.

## Interface
- `ExcludeReturns`, default 1: when 1, return-form jumps are not flagged.
- `CountCalls`, default 1: when 0, call-form jumps (rd = x1/x5) are not flagged.
- `CntWidth`, default 32: width of the statistics counters.
- `clk_i`  in  1  clock. One clock domain.
- `rst_ni`  in  1  reset, asynchronous and active-low.
- `enable_i`  in  1  when low, incoming instructions are ignored (treated as invalid).
- `flush_i`  in  1  drops all in-flight pipeline entries.
- `clear_i`  in  1  synchronously zeroes both statistics counters.
- `instr_valid_i`  in  1  retired-instruction strobe, one instruction per cycle.
- `instr_i`  in  32  retired instruction word; compressed instructions sit in [15:0].
- `instr_valid_o`  out  1  to `jop_alarm.instr_valid_i`.
- `is_ind_jump_o`  out  1  to `jop_alarm.is_ind_jump_i`; 0 whenever `instr_valid_o` = 0.
- `ind_jump_cnt_o`  out  CntWidth  number of flagged indirect jumps emitted.
- `instr_cnt_o`  out  CntWidth  number of valid instructions emitted.

## Operation
- Stage 1 (S1): registers valid (`instr_valid_i & enable_i`) and `instr_i`.
- Classification is combinational on S1, and the result is registered into stage 2 (S2). S2 drives the outputs.
- 32-bit form (instr[1:0] = 11). JALR when opcode[6:0] = 1100111 and funct3 = 000; rd = [11:7], rs1 = [19:15].
  - Return: rd = 0 and rs1 ∈ {1,5}.
  - Call: rd ∈ {1,5}.
- 16-bit form (instr[1:0] = 10, [15:13] = 100, [6:2] = 0, [11:7] ≠ 0); instr[31:16] is ignored.
  - C.JR when [12] = 0. It is a return when [11:7] ∈ {1,5}.
  - C.JALR when [12] = 1. It is always a call (implicit rd = x1).
  - C.JR/C.JALR with rs1 = 0 (reserved/C.EBREAK) is not a jump.
- Quadrant 00/01 words and any other encoding are not jumps.
- Flag rule: `is_jump & ~(ExcludeReturns & is_ret) & ~(~CountCalls & is_call)`.
  - If a JALR is both call and return (rd = x1, rs1 = x5), it is treated as a call only.
- Counters:
  - `instr_cnt_o` increments on each cycle where S2 valid is set.
  - `ind_jump_cnt_o` increments on each cycle where S2 valid and flag are both set.
  - Both saturate at 2^CntWidth−1 and never wrap.
- `clear_i` zeroes both counters. If a clear and an increment fall in the same cycle, clear wins and the counter ends at 0.
- `flush_i` clears S1 and S2 valid at the next edge.
  - If flush arrives together with a valid input, flush wins and the input is dropped.
  - Counters are unaffected by flush, except that flushed entries are never counted.
- `enable_i` gates only the input capture. Entries already in flight complete normally.

## Timing
- Reset values (asynchronous): S1/S2 valid = 0, `instr_valid_o` = 0, `is_ind_jump_o` = 0, both counters = 0. The instruction register is also reset to 0.
- Latency: an instruction captured at edge N appears on the outputs after edge N+1, i.e. 2 cycles from input to output.
- Throughput: 1 instruction per cycle. There is no backpressure; `jop_alarm` is always ready.
- Counters reflect S2 one cycle later: the count is updated at the edge after the entry is shown on `instr_valid_o`.
- Reset asserted mid-stream: all state clears immediately. The first output after reset release is the first instruction captured post-release.
- Back-to-back jumps produce consecutive `is_ind_jump_o` = 1 cycles with no bubble.

## Test plan
- JALR x0,0(x10) = 0x00050067 valid at cycle 0 -> `instr_valid_o` = `is_ind_jump_o` = 1 at cycle 2; `ind_jump_cnt_o` = 1, `instr_cnt_o` = 1 at cycle 3.
- ret 0x00008067, c.ret 0x8082, jal 0x0000006F, c.jr x0 0x8002 with ExcludeReturns = 1 -> `is_ind_jump_o` = 0 for all four, `instr_cnt_o` = 4. Repeat with ExcludeReturns = 0 -> ret and c.ret flagged, `ind_jump_cnt_o` = 2.
- c.jr a0 0x8502 and c.jalr a0 0x9502 with CountCalls = 1 -> both flagged. With CountCalls = 0 -> only 0x8502 flagged. Upper halfword = 0xFFFF has no effect.
- Stream of 5 consecutive 0x00050067 with `flush_i` pulsed in the cycle the 3rd is presented -> the 2nd and 3rd are dropped; `instr_cnt_o` = 3, `ind_jump_cnt_o` = 3. `enable_i` = 0 for 2 cycles drops exactly those 2 inputs.
- CntWidth = 4, 20 consecutive jumps -> both counters stick at 15. `clear_i` asserted together with a valid S2 -> both counters = 0 the next cycle.
- `rst_ni` asserted asynchronously with 2 jumps in flight -> all outputs 0 immediately. After release, nothing is emitted until new input arrives, and that input appears 2 cycles later.
